sar_scan_ctrl: RTL and testbench
================================

Name: sar_scan_ctrl

Overview:
- Multi-channel scan scheduler for the 8-bit SAR conversion FSM.
- Steps an analog input mux across enabled channels, allowing a settle time on each.
- Per channel: pulses the SAR's SOC, waits for EOC, captures the latched 8-bit Q and writes it with its channel index to a result register bank or FIFO.
- Sits between the system control logic and the SAR FSM; it is the only driver of SOC.

Parameters:
- NCH, 4, number of analog channels (2..16).
- CHW, 2, channel index width, equal to clog2(NCH).
- SETTLE_CYC, 3, mux settle cycles before SOC (1..255).
- TIMEOUT_CYC, 15, maximum cycles from SOC deassertion to EOC before error (>= 11).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a scan when idle, ignored while busy.
- continuous  in  1  sampled at start; 1 = rescan forever until stop.
- stop  in  1  one-cycle pulse; ends the scan after the current conversion completes.
- ch_mask  in  NCH  enabled channels, sampled at start.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when the scan ends (normal end, stop, or error).
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- mux_sel  out  CHW  analog mux select.
- soc  out  1  to SAR SOC.
- eoc  in  1  from SAR EOC.
- q  in  8  from SAR Q, valid from the cycle after eoc is first seen high.
- wr_en  out  1  one-cycle result write strobe.
- wr_ch  out  CHW  channel of the result.
- wr_data  out  8  result value.

Behaviour:
- Reset values: state=IDLE, soc=1 (holds the SAR in wait), busy=0, done=0, err=0, mux_sel=0, wr_en=0, wr_ch=0, wr_data=0, all counters 0.
- IDLE: soc=1.
  - On start with ch_mask != 0: latch mask and continuous, clear err, set mux_sel to the lowest enabled channel, go to SETTLE.
  - On start with ch_mask == 0: pulse done next cycle and stay in IDLE.
- SETTLE: count SETTLE_CYC cycles with soc=1, then go to CONV.
- CONV: soc=0. Count cycles from 0.
  - eoc=1 seen: go to CAPTURE.
  - Count reaches TIMEOUT_CYC without eoc: set err, soc=1, go to IDLE with done pulsed.
- CAPTURE: single cycle. wr_en=1, wr_ch=mux_sel, wr_data=q. soc returns to 1 in this cycle, which resets the SAR to wait. Then go to NEXT.
- NEXT: single cycle; select the next enabled channel above mux_sel.
  - Next channel found: go to SETTLE.
  - None left, continuous=1 and no stop pending: wrap to the lowest enabled channel and go to SETTLE.
  - Otherwise: go to IDLE with done pulsed.
- stop: latched as pending in any non-IDLE state and honoured in NEXT; the conversion in flight is always written. stop in IDLE is ignored.
- start while busy: ignored. start and stop in the same cycle from IDLE: start is accepted and stop is ignored.
- Latency: with SAR conversion of 10 cycles after SOC falls, one channel takes SETTLE_CYC + 1 (CONV detect) + 10 + 1 (CAPTURE) + 1 (NEXT) cycles. For defaults this is 16 cycles per channel.
- Asynchronous rst mid-scan: immediate return to reset values; no wr_en is issued for the partial conversion.

Optional Feature:
- SAR_SCAN_AVG_EN defined:
  - Each channel is converted 4 times, looping CAPTURE -> SETTLE on the same channel.
  - Samples are summed into a 10-bit accumulator; one wr_en is issued with wr_data = sum[9:2] (truncated mean).
  - A timeout on any of the 4 conversions aborts as in the base behaviour.
- Not defined: one conversion per channel; no accumulator logic is present.

Decomposition:
- Package sar_pkg holds:
  - state enum (IDLE, SETTLE, CONV, CAPTURE, NEXT);
  - SAR_W=8;
  - AVG_N=4 and AVG_SHIFT=2.
- One sub-module, sar_next_ch: combinational priority finder. Inputs mask and current index; outputs next index, a found flag, and the lowest enabled index.

Test Plan:
- Single scan: ch_mask=4'b1011, SAR model returns q=8'h10+ch. Expect wr_ch sequence 0,1,3 with wr_data 10,11,13 hex, then one done pulse and busy=0. Check defaults give 16 cycles per channel.
- Continuous with stop: mask=4'b0110, continuous=1, stop asserted during the third conversion. Expect writes 1,2,1, then done; no fourth SOC.
- Timeout: SAR model never raises eoc. Expect err=1 and done exactly TIMEOUT_CYC cycles after soc falls; soc=1, no wr_en. The next start clears err.
- Empty mask and ignored inputs: start with ch_mask=0 gives done the next cycle and busy stays 0. A start while busy causes no change in the sequence.
- Reset mid-CONV: rst pulsed asynchronously between clock edges. Outputs go to reset values immediately, with no wr_en; a new start runs normally.
- SAR_SCAN_AVG_EN: channel 0 returns 8'h40, 8'h41, 8'h42, 8'h43. Expect a single write with wr_data=8'h41 after 4 SOC pulses.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared state encoding and constants for the SAR multi-channel scan controller.
package sar_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, CONV, CAPTURE, NEXT} state_e;

    localparam int SAR_W     = 8;
    localparam int AVG_N     = 4;
    localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/sar_next_ch.sv
// Combinational channel finder: next enabled channel above cur, plus the
// lowest enabled channel for (re)starting a pass.
module sar_next_ch
    import sar_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] mask,
    input  logic [CHW-1:0] cur,
    output logic [CHW-1:0] nxt,
    output logic           found,
    output logic [CHW-1:0] lowest
);

    // Scanning downwards lets the last hit win, i.e. the lowest qualifying index.
    always_comb begin
        nxt    = '0;
        found  = 1'b0;
        lowest = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (CHW'(i) > cur)) begin
                nxt   = CHW'(i);
                found = 1'b1;
            end
            if (mask[i]) lowest = CHW'(i);
        end
    end

endmodule

// File: rtl/sar_scan_ctrl.sv
// Scan scheduler driving the SAR SOC across enabled mux channels.
// Define SAR_SCAN_AVG_EN to convert each channel 4x and write the truncated mean.
module sar_scan_ctrl
    import sar_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CHW         = 2,
    parameter int SETTLE_CYC  = 3,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    input  logic [NCH-1:0]   ch_mask,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CHW-1:0]   mux_sel,
    output logic             soc,
    input  logic             eoc,
    input  logic [SAR_W-1:0] q,
    output logic             wr_en,
    output logic [CHW-1:0]   wr_ch,
    output logic [SAR_W-1:0] wr_data
);

    localparam int CNT_W = 16;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [CHW-1:0]   sel_q, sel_d;
    logic             cont_q, cont_d;
    logic             stop_q, stop_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [NCH-1:0]   find_mask;
    logic [CHW-1:0]   nxt_ch, low_ch;
    logic             nxt_found;
    logic             wr_last;
    logic [SAR_W-1:0] wr_val;

    // In IDLE the finder looks at the live mask so the first channel is ready at start.
    assign find_mask = (state_q == IDLE) ? ch_mask : mask_q;

    sar_next_ch #(.NCH(NCH), .CHW(CHW)) u_next (
        .mask   (find_mask),
        .cur    (sel_q),
        .nxt    (nxt_ch),
        .found  (nxt_found),
        .lowest (low_ch)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        cont_d  = cont_q;
        stop_d  = stop_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (state_q != IDLE && stop) stop_d = 1'b1;
        case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (start) begin
                    if (ch_mask != '0) begin
                        mask_d  = ch_mask;
                        cont_d  = continuous;
                        err_d   = 1'b0;
                        sel_d   = low_ch;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = CONV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CONV: begin
                if (eoc) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: state_d = wr_last ? NEXT : SETTLE;
            NEXT: begin
                if (stop_q || stop) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (nxt_found) begin
                    sel_d   = nxt_ch;
                    state_d = SETTLE;
                end else if (cont_q) begin
                    sel_d   = low_ch;
                    state_d = SETTLE;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            cont_q  <= cont_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef SAR_SCAN_AVG_EN
    logic [SAR_W+AVG_SHIFT-1:0] acc_q, acc_d, acc_sum;
    logic [AVG_SHIFT-1:0]       avg_q, avg_d;

    assign acc_sum = acc_q + {{AVG_SHIFT{1'b0}}, q};
    assign wr_last = (avg_q == AVG_SHIFT'(AVG_N - 1));
    assign wr_val  = acc_sum[SAR_W+AVG_SHIFT-1:AVG_SHIFT];

    // Sample counter wraps to 0 after the last sample, ready for the next channel.
    always_comb begin
        acc_d = acc_q;
        avg_d = avg_q;
        if (state_q == CAPTURE) begin
            acc_d = wr_last ? '0 : acc_sum;
            avg_d = avg_q + 1'b1;
        end else if (state_q == IDLE) begin
            acc_d = '0;
            avg_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end
`else
    assign wr_last = 1'b1;
    assign wr_val  = q;
`endif

    assign busy    = (state_q != IDLE);
    assign soc     = (state_q != CONV);
    assign done    = done_q;
    assign err     = err_q;
    assign mux_sel = sel_q;
    assign wr_en   = (state_q == CAPTURE) && wr_last;
    assign wr_ch   = wr_en ? sel_q : '0;
    assign wr_data = wr_en ? wr_val : '0;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Randomized scoreboard bench for sar_scan_ctrl with a behavioural SAR model.
module tb_sar_scan_ctrl;

    localparam int NCH         = 4;
    localparam int CHW         = 2;
    localparam int SETTLE_CYC  = 3;
    localparam int TIMEOUT_CYC = 15;
    localparam int SAR_LAT     = 10;
`ifdef SAR_SCAN_AVG_EN
    localparam int CONVS = 4;
`else
    localparam int CONVS = 1;
`endif
    // Cycles between successive result writes: each conversion is settle +
    // detect + SAR latency + capture, plus one NEXT cycle per channel.
    localparam int CH_CYC = CONVS * (SETTLE_CYC + 1 + SAR_LAT + 1) + 1;

    logic           clk = 1'b0, rst = 1'b1;
    logic           start = 1'b0, continuous = 1'b0, stop = 1'b0;
    logic [NCH-1:0] ch_mask = '0;
    logic           busy, done, err, soc, eoc, wr_en;
    logic [CHW-1:0] mux_sel, wr_ch;
    logic [7:0]     q, wr_data;

    sar_scan_ctrl #(.NCH(NCH), .CHW(CHW), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
        .ch_mask(ch_mask), .busy(busy), .done(done), .err(err), .mux_sel(mux_sel),
        .soc(soc), .eoc(eoc), .q(q), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SAR model: held in wait while soc=1, raises eoc SAR_LAT cycles after soc falls.
    int tab[NCH];
    bit sar_dead = 1'b0;
    int sar_cnt, sar_k;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sar_cnt <= 0; eoc <= 1'b0; q <= '0; sar_k <= 0;
        end else if (soc) begin
            sar_cnt <= 0; eoc <= 1'b0;
        end else if (sar_cnt < SAR_LAT) begin
            sar_cnt <= sar_cnt + 1;
            if (sar_cnt == SAR_LAT - 1 && !sar_dead) begin
                eoc   <= 1'b1;
                q     <= 8'(tab[mux_sel] + sar_k % CONVS);
                sar_k <= sar_k + 1;
            end
        end
    end

    typedef struct packed { logic [CHW-1:0] ch; logic [7:0] data; } wr_t;
    wr_t exp_q[$];

    function automatic logic [7:0] exp_data(input int ch);
        int s = 0;
        for (int k = 0; k < CONVS; k++) s += tab[ch] + k;
        return 8'(s / CONVS);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write and keeps running totals.
    int tot_wr = 0, tot_done = 0, tot_falls = 0, fall_cyc = 0;
    int wr_cyc[4096];
    logic soc_prev = 1'b1;
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write ch=%0d data=%0h with nothing expected", wr_ch, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_ch", wr_ch, e.ch);
                chk("wr_data", wr_data, e.data);
            end
            wr_cyc[tot_wr % 4096] = cyc;
            tot_wr++;
        end
        if (done) tot_done++;
        if (soc_prev && !soc) begin
            tot_falls++;
            fall_cyc = cyc;
        end
        soc_prev = soc;
    end

    task automatic pulse_start(input logic [NCH-1:0] m, input bit c, input bit s);
        @(posedge clk); #1;
        start = 1'b1; ch_mask = m; continuous = c; stop = s;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        ch_mask = NCH'($urandom); continuous = 1'($urandom);
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        chk(name, seen, 1);
    endtask

    task automatic run_scan(input logic [NCH-1:0] m, input bit c, input int stop_after,
                            input bit extra_start, input bit stop_at_start);
        int chs[$];
        int n, b_wr, b_done, b_falls;
        for (int i = 0; i < NCH; i++) if (m[i]) chs.push_back(i);
        n = c ? stop_after : chs.size();
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.ch   = CHW'(chs[i % chs.size()]);
            e.data = exp_data(chs[i % chs.size()]);
            exp_q.push_back(e);
        end
        b_wr = tot_wr; b_done = tot_done; b_falls = tot_falls;
        pulse_start(m, c, stop_at_start);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
        if (extra_start) begin
            repeat (5) @(posedge clk);
            pulse_start(~m, !c, 1'b0);
        end
        if (c) begin
            for (int k = 0; k < 20000 && (tot_falls - b_falls) < (stop_after - 1) * CONVS + 1; k++)
                @(negedge clk);
            pulse_stop();
        end
        wait_done((n + 2) * CH_CYC + 100, "scan_done_seen");
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("write_count", tot_wr - b_wr, n);
        chk("done_pulses", tot_done - b_done, 1);
        chk("soc_pulses", tot_falls - b_falls, n * CONVS);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("err_clear_end", err, 0);
        for (int i = 1; i < n; i++)
            chk("ch_period", wr_cyc[(b_wr + i) % 4096] - wr_cyc[(b_wr + i - 1) % 4096], CH_CYC);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int b_wr, b_done;
        logic [NCH-1:0] m;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_soc", soc, 1);     chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);   chk("rst_err", err, 0);
        chk("rst_mux_sel", mux_sel, 0); chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_ch", wr_ch, 0); chk("rst_wr_data", wr_data, 0);

        // Single scan, q = 0x10 + channel
        for (int i = 0; i < NCH; i++) tab[i] = 16 + i;
        run_scan(4'b1011, 1'b0, 0, 1'b0, 1'b0);

        // Continuous with stop during the third conversion
        run_scan(4'b0110, 1'b1, 3, 1'b0, 1'b0);

        // Empty mask: done next cycle, never busy
        b_done = tot_done;
        pulse_start('0, 1'b0, 1'b0);
        @(negedge clk);
        chk("empty_done", done, 1);
        chk("empty_busy", busy, 0);
        @(negedge clk);
        chk("empty_done_clear", done, 0);
        chk("empty_busy_idle", busy, 0);
        chk("empty_done_pulses", tot_done - b_done, 1);

        // Stop while idle must not cut the next continuous scan short
        pulse_stop();
        run_scan(4'b1001, 1'b1, 2, 1'b0, 1'b0);

        // Timeout: SAR never answers
        sar_dead = 1'b1;
        b_wr = tot_wr;
        pulse_start(4'b0100, 1'b0, 1'b0);
        wait_done(SETTLE_CYC + TIMEOUT_CYC + 20, "timeout_done_seen");
        chk("timeout_latency", cyc - fall_cyc, TIMEOUT_CYC);
        chk("timeout_err", err, 1);
        chk("timeout_soc", soc, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_write", tot_wr - b_wr, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        sar_dead = 1'b0;
        run_scan(4'b0011, 1'b0, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-conversion
        pulse_start(4'b1110, 1'b0, 1'b0);
        for (int k = 0; k < 50 && soc; k++) @(negedge clk);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_soc", soc, 0);
        b_wr = tot_wr;
        rst = 1'b1;
        #1;
        chk("arst_soc", soc, 1);     chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);   chk("arst_err", err, 0);
        chk("arst_mux_sel", mux_sel, 0); chk("arst_wr_en", wr_en, 0);
        chk("arst_wr_ch", wr_ch, 0); chk("arst_wr_data", wr_data, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_no_write", tot_wr - b_wr, 0);
        run_scan(4'b0101, 1'b0, 0, 1'b0, 1'b0);

        // Averaging pattern on channel 0 (base 0x40)
        tab[0] = 'h40;
        run_scan(4'b0001, 1'b0, 0, 1'b0, 1'b0);

        // Randomized scans, including ignored start-while-busy and start+stop together
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NCH; i++) tab[i] = $urandom_range(0, 'hEF);
            m = NCH'($urandom_range(1, (1 << NCH) - 1));
            run_scan(m, 1'($urandom), $urandom_range(1, 5), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
